// File: rtl/swara_synth_pkg.sv
// swara_synth_pkg: window codes, player states and output scale shared by the swara_synth blocks
package swara_synth_pkg;

   typedef enum logic [1:0] {WIN_NONE, WIN_ASC, WIN_FALL, WIN_BOTH} win_e;

   typedef enum logic {ST_IDLE, ST_PLAY} state_e;

   // Sine peak is 0.9 of full scale, kept as an exact integer ratio
   localparam int SCALE_NUM = 9;
   localparam int SCALE_DEN = 10;

   function automatic int peak_amp(input int sample_w);
      return ((2 ** (sample_w - 1) - 1) * SCALE_NUM + SCALE_DEN / 2) / SCALE_DEN;
   endfunction

endpackage

// File: rtl/swara_sine_lut.sv
// swara_sine_lut: quarter-wave sine table with quadrant folding and a registered output
module swara_sine_lut
   import swara_synth_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int LUT_AW = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LUT_AW+1:0]          phase_idx,
   output logic signed [SAMPLE_W-1:0] sine_q
);

   localparam int DEPTH = 2 ** LUT_AW;
   localparam real PI = 3.14159265358979323846;

   // Entries sample the first quadrant at bin midpoints, so folding gives an exactly odd, mirror-symmetric wave
   function automatic logic [SAMPLE_W-1:0] quarter_val(input int a);
      return SAMPLE_W'($rtoi(real'(peak_amp(SAMPLE_W)) * $sin(real'(2 * a + 1) * PI / real'(4 * DEPTH)) + 0.5));
   endfunction

   logic [SAMPLE_W-1:0] tbl [DEPTH];
   logic [1:0] quad;
   logic [LUT_AW-1:0] addr;
   logic [SAMPLE_W-1:0] mag;
   logic signed [SAMPLE_W-1:0] sine_d;

   for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
      assign tbl[k] = quarter_val(k);
   end

   // Mirror the address in odd quadrants and negate over the lower half-wave
   always_comb begin
      quad = phase_idx[LUT_AW+1:LUT_AW];
      addr = quad[0] ? ~phase_idx[LUT_AW-1:0] : phase_idx[LUT_AW-1:0];
      mag = tbl[addr];
      sine_d = quad[1] ? -$signed(mag) : $signed(mag);
   end

   // One register stage on the table output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sine_q <= '0;
      else sine_q <= sine_d;
   end

endmodule

// File: rtl/swara_synth.sv
// swara_synth: one-note-buffered sine note player with envelope windows; SWARA_SYNTH_UNDERRUN_CNT_EN adds underrun_cnt
module swara_synth
   import swara_synth_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int PHASE_W = 24,
   parameter int LUT_AW = 8,
   parameter int N_SAMPLES = 13230,
   parameter int WN_LOG2 = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic                note_valid,
   output logic                note_ready,
   input  logic [PHASE_W-1:0]  note_inc,
   input  logic [1:0]          note_win,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample_out,
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
   output logic [15:0]         underrun_cnt,
`endif
   output logic                busy
);

   localparam int IW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
   localparam int GW = WN_LOG2 + 1;
   localparam int WN = 2 ** WN_LOG2;
   localparam int PW = SAMPLE_W + GW + 1;
   localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);

   logic buf_full_q, buf_full_d;
   logic [PHASE_W-1:0] buf_inc_q, buf_inc_d;
   logic [1:0] buf_win_q, buf_win_d;
   logic state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [PHASE_W-1:0] phase_q, phase_d, inc_q, inc_d, phase_sum;
   logic [1:0] win_q, win_d;
   logic vld1_q, vld1_d;
   logic [GW-1:0] gain1_q, gain1_d;
   logic sample_valid_q, sample_valid_d;
   logic signed [SAMPLE_W-1:0] out_q, out_d;
   logic accept, play_smp, note_end, load;
   logic [IW-1:0] rem;
   logic [GW-1:0] asc, fall, gain;
   logic signed [SAMPLE_W-1:0] sine;
   logic signed [PW-1:0] prod, shifted;

   swara_sine_lut #(
      .SAMPLE_W(SAMPLE_W),
      .LUT_AW(LUT_AW)
   ) u_lut (
      .clk(clk),
      .rst(rst),
      .phase_idx(phase_sum[PHASE_W-1 -: LUT_AW+2]),
      .sine_q(sine)
   );

   // Note buffer, play state, sample index and phase accumulator; a sample uses the freshly advanced phase
   always_comb begin
      accept = note_valid && !buf_full_q;
      play_smp = state_q == ST_PLAY && sample_en;
      note_end = play_smp && idx_q == LAST;
      load = buf_full_q && (state_q == ST_IDLE || note_end);
      phase_sum = phase_q + inc_q;
      phase_d = play_smp ? phase_sum : phase_q;
      idx_d = note_end || load ? '0 : play_smp ? idx_q + IW'(1) : idx_q;
      state_d = load ? ST_PLAY : note_end ? ST_IDLE : state_q;
      inc_d = load ? buf_inc_q : inc_q;
      win_d = load ? buf_win_q : win_q;
      buf_full_d = accept || (buf_full_q && !load);
      buf_inc_d = accept ? note_inc : buf_inc_q;
      buf_win_d = accept ? note_win : buf_win_q;
   end

   // Envelope gain and the two-stage scale pipeline; IDLE strobes carry zero gain so they emit 0
   always_comb begin
      rem = LAST - idx_q;
      asc = 32'(idx_q) >= WN ? GW'(WN) : GW'(idx_q);
      fall = 32'(rem) >= WN ? GW'(WN) : GW'(rem);
      gain = win_q == WIN_NONE ? GW'(WN) : win_q == WIN_ASC ? asc : win_q == WIN_FALL ? fall : asc < fall ? asc : fall;
      gain1_d = play_smp ? gain : '0;
      vld1_d = sample_en;
      prod = PW'(sine) * PW'($signed({1'b0, gain1_q}));
      shifted = prod >>> WN_LOG2;
      out_d = shifted[SAMPLE_W-1:0];
      sample_valid_d = vld1_q;
   end

   // State registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full_q <= 1'b0;
         buf_inc_q <= '0;
         buf_win_q <= '0;
         state_q <= ST_IDLE;
         idx_q <= '0;
         phase_q <= '0;
         inc_q <= '0;
         win_q <= '0;
         vld1_q <= 1'b0;
         gain1_q <= '0;
         sample_valid_q <= 1'b0;
         out_q <= '0;
      end else begin
         buf_full_q <= buf_full_d;
         buf_inc_q <= buf_inc_d;
         buf_win_q <= buf_win_d;
         state_q <= state_d;
         idx_q <= idx_d;
         phase_q <= phase_d;
         inc_q <= inc_d;
         win_q <= win_d;
         vld1_q <= vld1_d;
         gain1_q <= gain1_d;
         sample_valid_q <= sample_valid_d;
         out_q <= out_d;
      end
   end

`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
   logic [15:0] under_q, under_d;

   // Count note ends with nothing queued, saturating at all-ones
   always_comb under_d = note_end && !buf_full_q && under_q != 16'hFFFF ? under_q + 16'd1 : under_q;

   // Underrun counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) under_q <= '0;
      else under_q <= under_d;
   end

   assign underrun_cnt = under_q;
`endif

   assign note_ready = !buf_full_q;
   assign busy = state_q == ST_PLAY;
   assign sample_valid = sample_valid_q;
   assign sample_out = out_q;

endmodule

// File: tb/tb_swara_synth.sv
// tb_swara_synth: randomized bench for swara_synth against a note-level reference model
module tb_swara_synth;

   localparam int PW = 24;
   localparam int AW = 8;
   localparam int NS = 64;
   localparam int WL = 3;
   localparam int WN = 8;
   localparam int PEAK = 29490;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst, sample_en, note_valid, note_ready, sample_valid, busy;
   logic [23:0] note_inc;
   logic [1:0] note_win;
   logic [15:0] sample_out;
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   always #5 clk = ~clk;

   swara_synth #(
      .N_SAMPLES(NS),
      .WN_LOG2(WL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sample_en(sample_en),
      .note_valid(note_valid),
      .note_ready(note_ready),
      .note_inc(note_inc),
      .note_win(note_win),
      .sample_valid(sample_valid),
      .sample_out(sample_out),
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
      .underrun_cnt(underrun_cnt),
`endif
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: note queue, playing note, phase, and a 2-deep output delay line
   bit m_play, m_full;
   int m_idx, m_win, m_bwin, m_under;
   int unsigned m_phase, m_inc, m_binc;
   bit v1, v2, p1, p2;
   int o1, o2, i1, i2;
   int cap [NS];
   int unsigned ph_log [NS];
   bit off_v;
   int unsigned off_inc;
   int off_win;

   function automatic int sine_of(input int unsigned ph);
      int n;
      real x;
      n = int'(ph >> (PW - AW - 2));
      x = $sin((real'(n) + 0.5) * 2.0 * PI / real'(2 ** (AW + 2)));
      return x >= 0.0 ? $rtoi(real'(PEAK) * x + 0.5) : -$rtoi(-real'(PEAK) * x + 0.5);
   endfunction

   function automatic int gain_of(input int i, input int w);
      int a, f;
      a = i < WN ? i : WN;
      f = NS - 1 - i < WN ? NS - 1 - i : WN;
      if (w == 0) return WN;
      if (w == 1) return a;
      if (w == 2) return f;
      return a < f ? a : f;
   endfunction

   task automatic model_reset();
      m_play = 0; m_full = 0; m_idx = 0; m_phase = 0; m_inc = 0; m_win = 0; m_under = 0;
      v1 = 0; v2 = 0; p1 = 0; p2 = 0; o1 = 0; o2 = 0; i1 = 0; i2 = 0; off_v = 0;
   endtask

   task automatic model_edge(input bit se);
      bit acc;
      int unsigned ph;
      acc = off_v && !m_full;
      v2 = v1; o2 = o1; p2 = p1; i2 = i1;
      v1 = se; o1 = 0; p1 = 0; i1 = m_idx;
      if (m_play && se) begin
         ph = (m_phase + m_inc) & 32'h00FF_FFFF;
         o1 = (sine_of(ph) * gain_of(m_idx, m_win)) >>> WL;
         p1 = 1;
         ph_log[m_idx] = ph;
         m_phase = ph;
         if (m_idx == NS - 1) begin
            m_idx = 0;
            if (m_full) begin
               m_inc = m_binc; m_win = m_bwin; m_full = 0;
            end else begin
               m_play = 0;
               if (m_under < 65535) m_under++;
            end
         end else m_idx++;
      end else if (!m_play && m_full) begin
         m_play = 1; m_idx = 0; m_inc = m_binc; m_win = m_bwin; m_full = 0;
      end
      if (acc) begin
         m_full = 1; m_binc = off_inc; m_bwin = off_win; off_v = 0;
      end
   endtask

   // Called at a falling edge: compare this cycle's outputs, drive the next edge's inputs, advance the model
   task automatic cyc(input bit se);
      chk("sample_valid", sample_valid, v2);
      chk("sample_out", $signed(sample_out), o2);
      chk("busy", busy, m_play);
      chk("note_ready", note_ready, !m_full);
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
      chk("underrun_cnt", underrun_cnt, m_under);
`endif
      if (p2 && sample_valid) cap[i2] = $signed(sample_out);
      sample_en = se;
      note_valid = off_v;
      note_inc = off_inc[23:0];
      note_win = off_win[1:0];
      model_edge(se);
      @(negedge clk);
   endtask

   task automatic offer(input int unsigned inc, input int win);
      off_v = 1; off_inc = inc & 32'h00FF_FFFF; off_win = win;
   endtask

   initial begin
      int pk, busy_cyc, k;
      rst = 1; sample_en = 0; note_valid = 0; note_inc = 0; note_win = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_valid", sample_valid, 0);
      chk("reset_out", $signed(sample_out), 0);
      rst = 0;
      for (int c = 0; c < 40; c++) cyc(c % 4 == 0);

      // Plain note; the strobe on the load cycle must yield a zero sample
      offer(32'h0010_0000, 0);
      cyc(0);
      cyc(1);
      for (int c = 0; c < 280; c++) cyc(c % 4 == 3);
      pk = 0;
      for (int j = 0; j < NS; j++) if (cap[j] > pk) pk = cap[j];
      chk("peak_within_1lsb", pk >= PEAK - 1 && pk <= PEAK + 1, 1);
      for (int j = 0; j < 5; j++) begin
         k = j * 15;
         if (k > NS - 1) k = NS - 1;
         chk("win0_sample", cap[k], sine_of(((k + 1) << 20) & 32'h00FF_FFFF));
      end

      // Same note with both ramps
      offer(32'h0010_0000, 3);
      cyc(0);
      cyc(1);
      for (int c = 0; c < 280; c++) cyc(c % 4 == 3);
      chk("win3_first", cap[0], 0);
      chk("win3_last", cap[NS-1], 0);
      chk("win3_s4", cap[4], (sine_of(32'h0050_0000) * 4) >>> 3);
      for (int j = 8; j <= 55; j += 8) chk("win3_flat", cap[j], sine_of(((j + 1) << 20) & 32'h00FF_FFFF));

      // Back-to-back notes, second one buffered as soon as the first loads
      offer(32'h0010_0000, 1);
      cyc(0);
      cyc(0);
      offer(32'h000C_0000, 2);
      busy_cyc = 0;
      for (int c = 0; c < 600; c++) begin
         if (busy) busy_cyc++;
         cyc(c % 3 == 0);
      end
      chk("b2b_busy_cycles", busy_cyc, 2 * NS * 3 - 2);
      chk("b2b_first_of_second", cap[0], sine_of(32'h000C_0000));

      // Reset in the middle of a note with another note waiting
      offer($urandom, $urandom_range(0, 3));
      cyc(0);
      cyc(0);
      offer($urandom, $urandom_range(0, 3));
      for (int c = 0; c < 400 && !(m_play && m_idx == 31); c++) cyc(c % 2 == 0);
      chk("rst_point_reached", m_play && m_idx == 31, 1);
      #1 rst = 1;
      #1;
      chk("rst_async_valid", sample_valid, 0);
      chk("rst_async_out", $signed(sample_out), 0);
      chk("rst_async_busy", busy, 0);
      sample_en = 0;
      note_valid = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      chk("post_rst_ready", note_ready, 1);
      chk("post_rst_busy", busy, 0);
      for (int c = 0; c < 20; c++) cyc(1);

      // Three isolated notes, then a back-to-back pair
      for (int n = 0; n < 3; n++) begin
         offer($urandom, $urandom_range(0, 3));
         for (int c = 0; c < 200; c++) cyc(1);
      end
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
      chk("underrun_isolated", underrun_cnt, 3);
`endif
      offer($urandom, $urandom_range(0, 3));
      cyc(1);
      cyc(1);
      offer($urandom, $urandom_range(0, 3));
      for (int c = 0; c < 250; c++) cyc(1);
`ifdef SWARA_SYNTH_UNDERRUN_CNT_EN
      chk("underrun_b2b", underrun_cnt, 4);
`endif

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if (!off_v && $urandom_range(0, 99) < 3) offer($urandom, $urandom_range(0, 3));
         cyc($urandom_range(0, 2) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
